// File: rtl/ibex_id_issue_ctrl_if.sv
// LSU handshake bundle between the ID-stage issue controller and the LSU.
//   req  : issue controller requests a data access
//   we   : access is a store (valid with req)
//   gnt  : LSU accepts req this cycle
//   resp : load data or store ack returned, one-cycle pulse
//   err  : bus error, qualified by resp
// master = issue controller side, slave = LSU side.
interface ibex_id_issue_ctrl_if;
  logic req;
  logic we;
  logic gnt;
  logic resp;
  logic err;

  modport master (output req, output we, input gnt, input resp, input err);
  modport slave  (input req, input we, output gnt, output resp, output err);
endinterface

// File: rtl/ibex_id_issue_ctrl.sv
// ID-stage issue/sequencing controller.
// Fires ALU, mult/div and LSU work for the instruction in ID, holds the
// instruction for multi-cycle mult/div and until a store is acknowledged,
// tracks one outstanding load and stalls load-use hazards on it.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   instr_valid_i           instruction present in ID
//   dec_*                   decoder control and register addresses
//   lsu                     LSU handshake (req/we out, gnt/resp/err in)
//   instr_first_cycle_o     high while in DECODE (registered)
//   instr_ready_o           instruction consumed this cycle
//   illegal_o               illegal instruction consumed
//   multdiv_start_o         start pulse for the mult/div unit
//   rf_we_o                 ALU / mult-div result write enable
//   lsu_rf_we_o/_waddr_o    load data write-back
//   lsu_err_o               erroneous LSU response
//   stall_o                 valid instruction held this cycle
module ibex_id_issue_ctrl #(
  parameter int unsigned MulCycles = 3,
  parameter int unsigned DivCycles = 37
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        instr_valid_i,
  input  logic                        dec_illegal_i,
  input  logic                        dec_mult_en_i,
  input  logic                        dec_div_en_i,
  input  logic                        dec_data_req_i,
  input  logic                        dec_data_we_i,
  input  logic                        dec_rf_we_i,
  input  logic [4:0]                  dec_rf_waddr_i,
  input  logic [4:0]                  dec_rf_raddr_a_i,
  input  logic [4:0]                  dec_rf_raddr_b_i,
  input  logic                        dec_rf_ren_a_i,
  input  logic                        dec_rf_ren_b_i,
  ibex_id_issue_ctrl_if.master        lsu,
  output logic                        instr_first_cycle_o,
  output logic                        instr_ready_o,
  output logic                        illegal_o,
  output logic                        multdiv_start_o,
  output logic                        rf_we_o,
  output logic                        lsu_rf_we_o,
  output logic [4:0]                  lsu_rf_waddr_o,
  output logic                        lsu_err_o,
  output logic                        stall_o
);

  localparam int unsigned MaxCycles = (MulCycles > DivCycles) ? MulCycles : DivCycles;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MulLoad = CntW'(MulCycles - 1);
  localparam logic [CntW-1:0] DivLoad = CntW'(DivCycles - 1);

  localparam logic [1:0] StDecode    = 2'd0;
  localparam logic [1:0] StMuldiv    = 2'd1;
  localparam logic [1:0] StStoreWait = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            load_pend_q, load_pend_d;
  logic [4:0]      pend_rd_q, pend_rd_d;
  logic            first_q;
  logic            haz;
  logic            lsu_req, lsu_we;

  assign lsu.req             = lsu_req;
  assign lsu.we              = lsu_we;
  assign instr_first_cycle_o = first_q;

  // A returning response clears the hazard in the same cycle, so the
  // dependent instruction issues alongside the write-back.
  assign haz = load_pend_q & ~lsu.resp &
               (dec_data_req_i |
                (dec_rf_ren_a_i & (dec_rf_raddr_a_i == pend_rd_q)) |
                (dec_rf_ren_b_i & (dec_rf_raddr_b_i == pend_rd_q)) |
                (dec_rf_we_i    & (dec_rf_waddr_i   == pend_rd_q)));

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    load_pend_d     = load_pend_q;
    pend_rd_d       = pend_rd_q;
    instr_ready_o   = 1'b0;
    illegal_o       = 1'b0;
    multdiv_start_o = 1'b0;
    rf_we_o         = 1'b0;
    lsu_req         = 1'b0;
    lsu_we          = 1'b0;
    lsu_rf_we_o     = 1'b0;
    lsu_rf_waddr_o  = '0;
    lsu_err_o       = 1'b0;
    stall_o         = 1'b0;

    // Load completion is independent of the state; a grant later in this
    // block may overwrite the scoreboard with a new load.
    if (lsu.resp && load_pend_q) begin
      load_pend_d = 1'b0;
      if (lsu.err) begin
        lsu_err_o = 1'b1;
      end else begin
        lsu_rf_we_o    = 1'b1;
        lsu_rf_waddr_o = pend_rd_q;
      end
    end

    case (state_q)
      StDecode: begin
        if (instr_valid_i && !haz) begin
          if (dec_illegal_i) begin
            illegal_o     = 1'b1;
            instr_ready_o = 1'b1;
          end else if (dec_mult_en_i || dec_div_en_i) begin
            multdiv_start_o = 1'b1;
            cnt_d           = dec_mult_en_i ? MulLoad : DivLoad;
            state_d         = StMuldiv;
          end else if (dec_data_req_i) begin
            lsu_req = 1'b1;
            lsu_we  = dec_data_we_i;
            if (lsu.gnt) begin
              if (dec_data_we_i) begin
                state_d = StStoreWait;
              end else begin
                instr_ready_o = 1'b1;
                if (dec_rf_waddr_i != 5'd0) begin
                  load_pend_d = 1'b1;
                  pend_rd_d   = dec_rf_waddr_i;
                end
              end
            end
          end else begin
            instr_ready_o = 1'b1;
            rf_we_o       = dec_rf_we_i;
          end
        end
      end
      StMuldiv: begin
        if (cnt_q == '0) begin
          instr_ready_o = 1'b1;
          rf_we_o       = dec_rf_we_i;
          state_d       = StDecode;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StStoreWait: begin
        if (lsu.resp) begin
          instr_ready_o = 1'b1;
          lsu_err_o     = lsu.err;
          state_d       = StDecode;
        end
      end
      default: state_d = StDecode;
    endcase

    stall_o = ((state_q != StDecode) || instr_valid_i) && !instr_ready_o;

    // An operation caught by reset is aborted: suppress every strobe,
    // including a retire that would otherwise coincide with the reset.
    if (rst_i) begin
      instr_ready_o   = 1'b0;
      illegal_o       = 1'b0;
      multdiv_start_o = 1'b0;
      rf_we_o         = 1'b0;
      lsu_req         = 1'b0;
      lsu_we          = 1'b0;
      lsu_rf_we_o     = 1'b0;
      lsu_rf_waddr_o  = '0;
      lsu_err_o       = 1'b0;
      stall_o         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StDecode;
      cnt_q       <= '0;
      load_pend_q <= 1'b0;
      pend_rd_q   <= '0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_pend_q <= load_pend_d;
      pend_rd_q   <= pend_rd_d;
      first_q     <= (state_d == StDecode);
    end
  end

endmodule

// File: tb/tb_ibex_id_issue_ctrl.sv
module tb_ibex_id_issue_ctrl;
  localparam int unsigned MUL_C = 3;
  localparam int unsigned DIV_C = 37;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, valid, ill, mul, div, dreq, dwe, rfwe, rena, renb;
  logic [4:0] wa, ra, rb;
  logic       first_o, rdy_o, ill_o, start_o, rfwe_o, lrfwe_o, lerr_o, stall_o;
  logic [4:0] lwa_o;

  ibex_id_issue_ctrl_if lsu_bus();

  ibex_id_issue_ctrl #(.MulCycles(MUL_C), .DivCycles(DIV_C)) dut (
    .clk_i(clk), .rst_i(rst), .instr_valid_i(valid),
    .dec_illegal_i(ill), .dec_mult_en_i(mul), .dec_div_en_i(div),
    .dec_data_req_i(dreq), .dec_data_we_i(dwe), .dec_rf_we_i(rfwe),
    .dec_rf_waddr_i(wa), .dec_rf_raddr_a_i(ra), .dec_rf_raddr_b_i(rb),
    .dec_rf_ren_a_i(rena), .dec_rf_ren_b_i(renb), .lsu(lsu_bus),
    .instr_first_cycle_o(first_o), .instr_ready_o(rdy_o), .illegal_o(ill_o),
    .multdiv_start_o(start_o), .rf_we_o(rfwe_o), .lsu_rf_we_o(lrfwe_o),
    .lsu_rf_waddr_o(lwa_o), .lsu_err_o(lerr_o), .stall_o(stall_o)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which kind of work is outstanding, and the cycle a
  // mult/div is due to retire.
  int         cyc = 0;
  bit         m_md, m_st, m_pend;
  int         m_retire_at;
  logic [4:0] m_rd;
  bit         n_md, n_st, n_pend;
  int         n_retire_at;
  logic [4:0] n_rd;
  bit e_first, e_rdy, e_ill, e_start, e_rfwe, e_req, e_we, e_lrfwe, e_lerr, e_stall;
  logic [4:0] e_lwa;

  int stall_cnt, rdy_cnt, req_cnt;
  logic last_ill, last_rfwe, last_lrfwe, last_lerr, last_first;
  logic [4:0] last_lwa;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_eval();
    bit idle, haz;
    {e_rdy, e_ill, e_start, e_rfwe, e_req, e_we, e_lrfwe, e_lerr, e_stall} = '0;
    e_lwa = '0;
    n_md = m_md; n_st = m_st; n_pend = m_pend; n_rd = m_rd; n_retire_at = m_retire_at;
    idle    = !m_md && !m_st;
    e_first = idle;
    if (rst) begin
      n_md = 0; n_st = 0; n_pend = 0;
      return;
    end
    haz = m_pend && !lsu_bus.resp &&
          (dreq || (rena && ra == m_rd) || (renb && rb == m_rd) || (rfwe && wa == m_rd));
    if (m_pend && lsu_bus.resp) begin
      n_pend = 0;
      if (lsu_bus.err) e_lerr = 1;
      else begin e_lrfwe = 1; e_lwa = m_rd; end
    end
    if (idle && valid && !haz) begin
      if (ill) begin
        e_ill = 1; e_rdy = 1;
      end else if (mul || div) begin
        e_start = 1; n_md = 1;
        n_retire_at = cyc + int'(mul ? MUL_C : DIV_C);
      end else if (dreq) begin
        e_req = 1; e_we = dwe;
        if (lsu_bus.gnt) begin
          if (dwe) n_st = 1;
          else begin
            e_rdy = 1;
            if (wa != 0) begin n_pend = 1; n_rd = wa; end
          end
        end
      end else begin
        e_rdy = 1; e_rfwe = rfwe;
      end
    end
    if (m_md && cyc == m_retire_at) begin
      e_rdy = 1; e_rfwe = rfwe; n_md = 0;
    end
    if (m_st && lsu_bus.resp) begin
      e_rdy = 1; e_lerr = lsu_bus.err; n_st = 0;
    end
    e_stall = (!idle || valid) && !e_rdy;
  endtask

  // Called at a falling edge with inputs already driven.
  task automatic tick();
    #1;
    model_eval();
    chk("first_cycle", first_o, e_first);
    chk("ready", rdy_o, e_rdy);
    chk("illegal", ill_o, e_ill);
    chk("md_start", start_o, e_start);
    chk("rf_we", rfwe_o, e_rfwe);
    chk("lsu_req", lsu_bus.req, e_req);
    if (e_req) chk("lsu_we", lsu_bus.we, e_we);
    chk("lsu_rf_we", lrfwe_o, e_lrfwe);
    if (e_lrfwe) chk("lsu_rf_waddr", lwa_o, e_lwa);
    chk("lsu_err", lerr_o, e_lerr);
    chk("stall", stall_o, e_stall);
    stall_cnt += int'(stall_o); rdy_cnt += int'(rdy_o); req_cnt += int'(lsu_bus.req);
    last_ill = ill_o; last_rfwe = rfwe_o; last_lrfwe = lrfwe_o;
    last_lerr = lerr_o; last_lwa = lwa_o; last_first = first_o;
    @(posedge clk);
    cyc++;
    m_md = n_md; m_st = n_st; m_pend = n_pend; m_rd = n_rd; m_retire_at = n_retire_at;
    @(negedge clk);
  endtask

  task automatic set_instr(input logic v, input logic i_ill, input logic i_mul, input logic i_div,
                           input logic i_dreq, input logic i_dwe, input logic i_rfwe,
                           input logic [4:0] i_wa, input logic [4:0] i_ra, input logic i_rena,
                           input logic [4:0] i_rb, input logic i_renb);
    valid = v; ill = i_ill; mul = i_mul; div = i_div; dreq = i_dreq; dwe = i_dwe;
    rfwe = i_rfwe; wa = i_wa; ra = i_ra; rena = i_rena; rb = i_rb; renb = i_renb;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; rdy_cnt = 0; req_cnt = 0;
  endtask

  initial begin
    bit need_new;
    int r;
    rst = 1'b1;
    set_instr(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    lsu_bus.gnt = 0; lsu_bus.resp = 0; lsu_bus.err = 0;
    m_md = 0; m_st = 0; m_pend = 0; m_rd = '0; m_retire_at = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    tick();
    chk("rst_first", last_first, 1);

    // ALU back-to-back: SUB x1, AND x4
    clr_cnt();
    set_instr(1, 0, 0, 0, 0, 0, 1, 5'd1, 5'd2, 1, 5'd3, 1); tick();
    set_instr(1, 0, 0, 0, 0, 0, 1, 5'd4, 5'd1, 1, 5'd5, 1); tick();
    chk("alu_b2b_ready", rdy_cnt, 2);
    chk("alu_b2b_stall", stall_cnt, 0);

    // MUL x7: stalled three cycles, retires in the fourth
    clr_cnt();
    set_instr(1, 0, 1, 0, 0, 0, 1, 5'd7, 5'd8, 1, 5'd9, 1);
    repeat (MUL_C + 1) tick();
    chk("mul_stall", stall_cnt, 3);
    chk("mul_ready", rdy_cnt, 1);
    chk("mul_rfwe", last_rfwe, 1);

    // DIV (mult has priority when both set is covered in random)
    clr_cnt();
    set_instr(1, 0, 0, 1, 0, 0, 1, 5'd10, 5'd8, 1, 5'd9, 1);
    repeat (DIV_C + 1) tick();
    chk("div_stall", stall_cnt, 37);
    chk("div_ready", rdy_cnt, 1);

    // Load-use: LW x17 granted, consumer of x17 stalls until response
    set_instr(1, 0, 0, 0, 1, 0, 1, 5'd17, 5'd2, 1, 5'd0, 0);
    lsu_bus.gnt = 1; tick();
    lsu_bus.gnt = 0;
    clr_cnt();
    set_instr(1, 0, 0, 0, 0, 0, 1, 5'd5, 5'd17, 1, 5'd0, 1);
    repeat (3) tick();
    chk("lu_stall", stall_cnt, 3);
    chk("lu_held", rdy_cnt, 0);
    lsu_bus.resp = 1; tick();
    lsu_bus.resp = 0;
    chk("lu_wb_we", last_lrfwe, 1);
    chk("lu_wb_addr", last_lwa, 17);
    chk("lu_retire", rdy_cnt, 1);

    // Store: grant withheld 2 cycles, response 3 cycles after grant
    clr_cnt();
    set_instr(1, 0, 0, 0, 1, 1, 0, 5'd0, 5'd3, 1, 5'd4, 1);
    repeat (2) tick();
    lsu_bus.gnt = 1; tick();
    lsu_bus.gnt = 0;
    repeat (2) tick();
    lsu_bus.resp = 1; tick();
    lsu_bus.resp = 0;
    chk("st_req_cycles", req_cnt, 3);
    chk("st_ready", rdy_cnt, 1);

    // Illegal with rf_we set: no write
    set_instr(1, 1, 0, 0, 0, 0, 1, 5'd6, 5'd0, 0, 5'd0, 0); tick();
    chk("ill_pulse", last_ill, 1);
    chk("ill_no_rfwe", last_rfwe, 0);

    // Load with error response
    set_instr(1, 0, 0, 0, 1, 0, 1, 5'd9, 5'd1, 1, 5'd0, 0);
    lsu_bus.gnt = 1; tick();
    lsu_bus.gnt = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    tick();
    lsu_bus.resp = 1; lsu_bus.err = 1; tick();
    lsu_bus.resp = 0; lsu_bus.err = 0;
    chk("lderr_err", last_lerr, 1);
    chk("lderr_no_we", last_lrfwe, 0);

    // Reset during DIV, then a late load response after reset is ignored
    set_instr(1, 0, 0, 1, 0, 0, 1, 5'd11, 5'd1, 1, 5'd2, 1);
    repeat (20) tick();
    rst = 1; tick();
    rst = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    tick();
    chk("rst_div_first", last_first, 1);
    set_instr(1, 0, 0, 0, 1, 0, 1, 5'd3, 5'd1, 1, 5'd0, 0);
    lsu_bus.gnt = 1; tick();
    lsu_bus.gnt = 0;
    rst = 1; tick();
    rst = 0;
    set_instr(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0);
    lsu_bus.resp = 1; tick();
    lsu_bus.resp = 0;
    chk("late_resp_ignored", last_lrfwe, 0);

    // Randomized traffic against the model
    need_new = 1;
    for (int i = 0; i < 800; i++) begin
      if (!(m_md || m_st) && need_new) begin
        r    = $urandom_range(0, 99);
        ill  = (r < 5);
        mul  = (r >= 5 && r < 13) || (r < 5 && $urandom_range(0, 1) == 1);
        div  = (r >= 13 && r < 16) || (r >= 5 && r < 13 && $urandom_range(0, 3) == 0);
        dreq = (r >= 16 && r < 50) || (r < 16 && $urandom_range(0, 1) == 1);
        dwe  = (r >= 38 && r < 50) || $urandom_range(0, 3) == 0;
        rfwe = $urandom_range(0, 1) == 1;
        wa   = 5'($urandom_range(0, 7));
        ra   = 5'($urandom_range(0, 7));
        rb   = 5'($urandom_range(0, 7));
        rena = $urandom_range(0, 1) == 1;
        renb = $urandom_range(0, 1) == 1;
        valid = $urandom_range(0, 99) < 85;
      end else if (m_md || m_st) begin
        valid = 1;
      end
      lsu_bus.gnt  = $urandom_range(0, 1) == 1;
      lsu_bus.resp = $urandom_range(0, 3) == 0;
      lsu_bus.err  = $urandom_range(0, 4) == 0;
      rst          = $urandom_range(0, 199) == 0;
      tick();
      need_new = e_rdy || !valid || rst;
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_id_issue_ctrl.md
# ibex_id_issue_ctrl

Issue/sequencing controller for the ID stage, sitting between the fetch interface, `ibex_decoder` and the execute resources (ALU, multiplier/divider, LSU). It takes decoded control signals for the instruction in ID and decides when to fire each resource. It holds the instruction for multi-cycle mult/div operations and for store completion. It tracks one outstanding load in a scoreboard, stalls load-use hazards, and generates `instr_first_cycle` for the decoder and the retire and writeback-enable strobes.

## Interface
- `MulCycles`, default 3: cycles spent in MULDIV for a multiply; must be ≥1.
- `DivCycles`, default 37: cycles spent in MULDIV for a divide or remainder; must be ≥1.
- `clk_i`  in  1  clock; all logic is on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `instr_valid_i`  in  1  instruction present in ID.
- `dec_illegal_i`, `dec_mult_en_i`, `dec_div_en_i`, `dec_data_req_i`, `dec_data_we_i`, `dec_rf_we_i`  in  1 each  decoder outputs.
- `dec_rf_waddr_i`, `dec_rf_raddr_a_i`, `dec_rf_raddr_b_i`  in  5 each  decoder register addresses.
- `dec_rf_ren_a_i`, `dec_rf_ren_b_i`  in  1 each  decoder register-read enables.
- `lsu_gnt_i`  in  1  LSU accepts `lsu_req_o` this cycle.
- `lsu_resp_i`  in  1  load data or store ack returned; one-cycle pulse.
- `lsu_err_i`  in  1  bus error; qualified by `lsu_resp_i`.
- `instr_first_cycle_o`  out  1  to decoder; high while in DECODE.
- `instr_ready_o`  out  1  instruction consumed (retired or handed to LSU) this cycle.
- `illegal_o`  out  1  pulse when an illegal instruction is consumed.
- `multdiv_start_o`  out  1  pulse that starts the mult/div unit.
- `lsu_req_o`, `lsu_we_o`  out  1 each  LSU request and write flag.
- `rf_we_o`  out  1  write enable for ALU or mult/div results.
- `lsu_rf_we_o`  out  1  write enable for load data.
- `lsu_rf_waddr_o`  out  5  destination register for load data.
- `lsu_err_o`  out  1  pulse on an erroneous response.
- `stall_o`  out  1  valid instruction held this cycle.

## Operation
- **States:** DECODE, MULDIV, STORE_WAIT. The reset state is DECODE.
- **Reset:** all outputs are 0 except `instr_first_cycle_o`, which is 1. `load_pend` is 0 and the counter is 0.
- **Scoreboard:** `load_pend` plus a 5-bit `pend_rd`.
  - `haz` = `load_pend` & ~`lsu_resp_i` & (`dec_data_req_i` | (`dec_rf_ren_a_i` & `raddr_a`==`pend_rd`) | (`dec_rf_ren_b_i` & `raddr_b`==`pend_rd`) | (`dec_rf_we_i` & `waddr`==`pend_rd`)).
  - A returning response therefore releases a stall in the same cycle.
- **DECODE, `instr_valid_i` & ~`haz`.** Priority order:
  1. Illegal: pulse `illegal_o` and `instr_ready_o`. No resource fires and `rf_we_o` stays 0.
  2. Mult or div: pulse `multdiv_start_o`, load the counter with (`MulCycles` or `DivCycles`)−1, go to MULDIV. `dec_mult_en_i` wins if both are set.
  3. `dec_data_req_i`: assert `lsu_req_o` and `lsu_we_o`=`dec_data_we_i`. Hold (`stall_o`=1) until `lsu_gnt_i`. On grant:
     - Load: set `load_pend`, capture `pend_rd`=`dec_rf_waddr_i`, assert `instr_ready_o`.
     - Store: go to STORE_WAIT with no ready.
     - A load with rd=x0 does not set `load_pend`.
  4. Otherwise (ALU instruction): `instr_ready_o`=1 and `rf_we_o`=`dec_rf_we_i`.
- **DECODE, `instr_valid_i` & `haz`:** `stall_o`=1 and nothing fires.
- **MULDIV:** if counter==0, assert `instr_ready_o` and `rf_we_o`=`dec_rf_we_i`, then go to DECODE. Otherwise decrement. `stall_o`=1 until retire.
- **STORE_WAIT:** on `lsu_resp_i`, assert `instr_ready_o` and go to DECODE. Pulse `lsu_err_o` if `lsu_err_i`.
- **Load response** (`lsu_resp_i` & `load_pend`, any state):
  - No error: `lsu_rf_we_o`=1, `lsu_rf_waddr_o`=`pend_rd`, then clear `load_pend`.
  - Error: `lsu_rf_we_o`=0 and `lsu_err_o`=1.
  - If a new load is granted in the same cycle, the new `pend_rd` wins and `load_pend` stays 1.
- **Stray response:** `lsu_resp_i` with no load pending, outside STORE_WAIT, is ignored.
- **Counter width:** $clog2(max(`MulCycles`,`DivCycles`)). It never wraps; decrementing stops at 0.

## Timing
- **ALU / illegal:** consumed in the same cycle as valid, with zero added latency (ready is combinational).
- **Mult:** start in cycle N, retire in cycle N+`MulCycles`. Div behaves the same with `DivCycles`.
- **Load:** consumed in the grant cycle. Write-back occurs in the `lsu_resp_i` cycle.
- **Store:** retires in the response cycle.
- **Outputs:** `instr_first_cycle_o` is registered from state. All strobes are combinational from state and inputs and last exactly one cycle.
- **Reset mid-operation:** the operation is aborted with no retire strobe. `load_pend` clears, so a late response is then ignored.

## Test plan
- **ALU back-to-back:** SUB x1 then AND x4, valid held high → `instr_ready_o` and `rf_we_o` high in two consecutive cycles; `stall_o`=0.
- **MUL:** MUL x7 issued at cycle 10 → `multdiv_start_o` at 10; ready and `rf_we_o` at 13; `stall_o` high 10–12. DIV → retire at +37.
- **Load-use:** LW x17 granted at cycle 5, next instruction reads x17, `lsu_resp_i` at cycle 9 → `stall_o` high 6–8; at cycle 9 `lsu_rf_we_o`=1, `lsu_rf_waddr_o`=17 and the dependent instruction retires.
- **Store with delays:** SW with grant withheld 2 cycles, then response 3 cycles after grant → `lsu_req_o` high 3 cycles; ready only in the response cycle.
- **Illegal + load error:** an illegal instruction gives `illegal_o` and ready with `rf_we_o`=0. A load response with `lsu_err_i` gives `lsu_err_o`=1 with `lsu_rf_we_o`=0.
- **Reset during DIV:** `rst_i` asserted at cycle 20 of a DIV → no retire; next cycle in DECODE with all outputs at their reset values.
